eff_uart_tx: RTL and testbench

Transmit-side end of the effect chain. Accepts processed bytes from an effect stage (e.g. the clipping stage) through a one-cycle valid strobe, and buffers them in a small FIFO. Serializes each byte onto the UART TX line as 8N1, LSB first, at BAUD_RATE. It is the return path to the host, mirroring the RX side that feeds the effects.

---
 rtl/eff_uart_pkg.sv | 21 ++
 rtl/eff_byte_fifo.sv | 59 +++++
 rtl/eff_uart_tx.sv | 129 ++++++++++++
 tb/tb_eff_uart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/eff_uart_pkg.sv
// Shared UART definitions for the effect chain (TX and RX sides).
// Holds the FSM state type, the frame levels and the baud divisor helper.
package eff_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/eff_byte_fifo.sv
// Synchronous FIFO with registered full/empty/count and a first-word-fall-through read port.
// Full is taken from the register, so a write to a full FIFO is refused even when a pop happens that cycle.
module eff_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count_nxt;
  logic              wr_ok, rd_ok;

  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/eff_uart_tx.sv
// UART transmitter for the effect chain return path: byte FIFO + 8N1 serializer, LSB first.
// Define EFF_UART_TX_PARITY_EN to insert an even-parity bit after D7 (8E1 frame).
module eff_uart_tx
  import eff_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       data_valid,
  input  logic [7:0] tx_byte,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_fifo_full,
  output logic       o_overflow
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

  generate
    if (CPB < 2) begin : g_bad_baud
      $error("eff_uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("eff_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  tx_state_t                   state;
  logic [CW-1:0]               baud_cnt;
  logic [2:0]                  bit_idx;
  logic [DATA_BITS-1:0]        shreg;
  logic [DATA_BITS-1:0]        fifo_rd;
  logic                        fifo_full, fifo_empty, pop, bit_end;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef EFF_UART_TX_PARITY_EN
  logic                        par_bit;
`endif

  eff_byte_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr_en   (data_valid),
    .wr_data (tx_byte),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign pop         = (state == IDLE) & ~fifo_empty;
  assign bit_end     = (baud_cnt == CW'(CPB - 1));
  assign o_busy      = (state != IDLE) | (fifo_count != '0);
  assign o_fifo_full = fifo_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_overflow <= 1'b0;
    else       o_overflow <= data_valid & fifo_full;
  end

  // o_tx is loaded on the same edge as the state change, so the line level
  // always matches the state being entered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      o_tx     <= IDLE_LEVEL;
`ifdef EFF_UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          bit_idx <= '0;
          if (pop) begin
            shreg   <= fifo_rd;
`ifdef EFF_UART_TX_PARITY_EN
            par_bit <= ^fifo_rd;
`endif
            state   <= START;
            o_tx    <= START_LEVEL;
          end
        end
        START: if (bit_end) begin
          state <= DATA;
          o_tx  <= shreg[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef EFF_UART_TX_PARITY_EN
            state <= PARITY;
            o_tx  <= par_bit;
`else
            state <= STOP;
            o_tx  <= IDLE_LEVEL;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= shreg >> 1;
            o_tx    <= shreg[1];
          end
        end
`ifdef EFF_UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state <= STOP;
          o_tx  <= IDLE_LEVEL;
        end
`endif
        STOP: if (bit_end) begin
          state <= IDLE;
          o_tx  <= IDLE_LEVEL;
        end
        default: begin
          state <= IDLE;
          o_tx  <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eff_uart_tx.sv
// Scoreboard bench for eff_uart_tx at 10 clocks/bit: a line monitor rebuilds each frame
// cycle by cycle and compares it against the expected frame of the byte popped from the queue.
module tb_eff_uart_tx;

  localparam int CPB = 10;
`ifdef EFF_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       data_valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       o_tx, o_busy, o_fifo_full, o_overflow;

  eff_uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .data_valid  (data_valid),
    .tx_byte     (tx_byte),
    .o_tx        (o_tx),
    .o_busy      (o_busy),
    .o_fifo_full (o_fifo_full),
    .o_overflow  (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  int ovf_cnt = 0;
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) if (o_overflow) ovf_cnt <= ovf_cnt + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_frame(input logic [7:0] b);
    logic [127:0] v;
    int k;
    v = '0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      k = i / CPB;
      if (k == 0)                    v[i] = 1'b0;
      else if (k <= 8)               v[i] = b[k-1];
      else if (FRAME_BITS == 11 && k == 9) v[i] = ^b;
      else                           v[i] = 1'b1;
    end
    return v;
  endfunction

  // Scoreboard and line monitor
  logic [7:0]   sb[$];
  int           starts[$];
  logic         mon_en = 1'b1;
  logic         in_frame = 1'b0;
  int           pos = 0;
  logic [127:0] frm, last_frm;

  initial begin
    logic [7:0] b;
    frm = '0;
    last_frm = '0;
    forever begin
      @(negedge i_clk);
      if (!mon_en || i_rst) in_frame = 1'b0;
      else begin
        if (!in_frame && o_tx == 1'b0) begin
          in_frame = 1'b1;
          pos = 0;
          frm = '0;
          starts.push_back(cyc);
        end
        if (in_frame) begin
          frm[pos] = o_tx;
          pos++;
          if (pos == FRAME_CYC) begin
            in_frame = 1'b0;
            last_frm = frm;
            if (sb.size() == 0) chk("unexpected_frame", frm, 128'(0));
            else begin
              b = sb.pop_front();
              chk($sformatf("frame_%02h", b), frm, exp_frame(b));
            end
          end
        end
      end
    end
  end

  int last_drive;

  task automatic drive(input logic [7:0] b, input logic push);
    @(negedge i_clk);
    data_valid = 1'b1;
    tx_byte    = b;
    last_drive = cyc;
    if (push) sb.push_back(b);
  endtask

  task automatic release_in();
    @(negedge i_clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((o_busy || in_frame) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_idle"}, 128'(o_busy), 128'(0));
    @(negedge i_clk);
  endtask

  // One byte into an idle transmitter: check start latency and busy fall time.
  task automatic send_timed(input string tag, input logic [7:0] b);
    int n0, n;
    drive(b, 1'b1);
    n0 = last_drive;
    release_in();
    n = 0;
    while (o_tx !== 1'b0 && n < 20) begin @(negedge i_clk); n++; end
    chk({tag, "_start_cyc"}, 128'(cyc), 128'(n0 + 2));
    n = 0;
    while (o_busy && n < FRAME_CYC + 40) begin @(negedge i_clk); n++; end
    chk({tag, "_busy_fall_cyc"}, 128'(cyc), 128'(n0 + 2 + FRAME_CYC));
    @(negedge i_clk);
  endtask

  initial begin
    int s, lows, n;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_tx", 128'(o_tx), 128'(1));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_full", 128'(o_fifo_full), 128'(0));
    chk("rst_ovf", 128'(o_overflow), 128'(0));

    // Single byte
    send_timed("t1", 8'hA5);
    chk("t1_ovf_cnt", 128'(ovf_cnt), 128'(0));
    chk("t1_sb_drained", 128'(sb.size()), 128'(0));

    // Back-to-back
    starts.delete();
    drive(8'h00, 1'b1);
    drive(8'hFF, 1'b1);
    release_in();
    wait_idle("t2", 3 * FRAME_CYC);
    chk("t2_nstarts", 128'(starts.size()), 128'(2));
    if (starts.size() == 2)
      chk("t2_start_gap", 128'(starts[1] - starts[0]), 128'(FRAME_CYC + 1));

    // Overflow: 10 writes, the 10th is dropped
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        @(negedge i_clk);
        chk("t3_full_after_9", 128'(o_fifo_full), 128'(1));
        chk("t3_no_ovf_yet", 128'(o_overflow), 128'(0));
        data_valid = 1'b1;
        tx_byte    = 8'h19;
      end else begin
        drive(8'h10 + 8'(i), 1'b1);
      end
    end
    release_in();
    chk("t3_ovf_pulse", 128'(o_overflow), 128'(1));
    @(negedge i_clk);
    chk("t3_ovf_one_cycle", 128'(o_overflow), 128'(0));
    wait_idle("t3", 10 * (FRAME_CYC + 1) + 50);
    chk("t3_ovf_cnt", 128'(ovf_cnt), 128'(1));
    chk("t3_sb_drained", 128'(sb.size()), 128'(0));
    chk("t3_full_clear", 128'(o_fifo_full), 128'(0));

    // Reset mid-frame during D3 of 0x5A with three bytes queued
    mon_en = 1'b0;
    drive(8'h5A, 1'b0);
    drive(8'h11, 1'b0);
    drive(8'h22, 1'b0);
    drive(8'h33, 1'b0);
    release_in();
    n = 0;
    while (o_tx !== 1'b0 && n < 20) begin @(negedge i_clk); n++; end
    chk("t4_start_seen", 128'(o_tx), 128'(0));
    s = cyc;
    while (cyc < s + 4 * CPB + 4) @(negedge i_clk);
    chk("t4_d3_level", 128'(o_tx), 128'(1));
    i_rst = 1'b1;
    #1;
    chk("t4_rst_tx", 128'(o_tx), 128'(1));
    chk("t4_rst_busy", 128'(o_busy), 128'(0));
    chk("t4_rst_full", 128'(o_fifo_full), 128'(0));
    @(negedge i_clk);
    i_rst = 1'b0;
    mon_en = 1'b1;
    lows = 0;
    repeat (4 * FRAME_CYC) begin
      @(negedge i_clk);
      if (o_tx == 1'b0 || o_busy) lows++;
    end
    chk("t4_no_frames_after", 128'(lows), 128'(0));

    // Parity bit / frame length
    send_timed("t5_07", 8'h07);
`ifdef EFF_UART_TX_PARITY_EN
    chk("t5_par_07", 128'(last_frm[95]), 128'(1));
    send_timed("t5_a5", 8'hA5);
    chk("t5_par_a5", 128'(last_frm[95]), 128'(0));
`else
    chk("t5_stop_07", 128'(last_frm[95]), 128'(1));
`endif
    chk("t5_sb_drained", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
